// File: rtl/fir_uart_rx_pkg.sv
// Shared definitions for the FIR UART receive front end.
// Optional build macro: FIR_UART_RX_PARITY_EN (even-parity bit between data and stop).
package fir_uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_t;

    // Even parity of a data byte: the parity bit on the line must equal this.
    function automatic logic even_parity(input logic [BYTE_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fir_uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser plus 8N1 bit FSM (8E1 when
// FIR_UART_RX_PARITY_EN is defined). byte_done_o / byte_err_o are decoded
// from registered state in the stop-bit sample cycle, so the consumer sees
// them on the very edge the stop bit is sampled.
module uart_rx_byte
    import fir_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_data_o,
    output logic              byte_done_o,
    output logic              byte_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);

    logic              sync1_q;
    logic              sync2_q;
    rx_state_t         state_q,   state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic              par_err_q, par_err_d;
    logic              done_s;
    logic              err_s;

    // Bring the asynchronous serial line into the clk domain (idle high).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Bit FSM: start-bit qualification at half a bit, then mid-bit sampling.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = {CW{1'b0}};
                if (!sync2_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_TERM) begin
                    clk_cnt_d = {CW{1'b0}};
                    bit_cnt_d = 3'd0;
                    par_err_d = 1'b0;
                    // A line that is high again at mid start bit was a glitch.
                    if (!sync2_q) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_TERM) begin
                    clk_cnt_d = {CW{1'b0}};
                    shift_d   = {sync2_q, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef FIR_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`ifdef FIR_UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == FULL_TERM) begin
                    clk_cnt_d = {CW{1'b0}};
                    par_err_d = sync2_q ^ even_parity(shift_q);
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == FULL_TERM) begin
                    clk_cnt_d = {CW{1'b0}};
                    par_err_d = 1'b0;
                    state_d   = IDLE;
                    // Parity errors are reported here so both error kinds
                    // share a single report point.
                    if (sync2_q && !par_err_q) begin
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = {CW{1'b0}};
                par_err_d = 1'b0;
            end
        endcase
    end

    // FSM, counters and byte shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clk_cnt_q <= {CW{1'b0}};
            bit_cnt_q <= 3'd0;
            shift_q   <= {BYTE_W{1'b0}};
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    assign byte_data_o = shift_q;
    assign byte_done_o = done_s;
    assign byte_err_o  = err_s;

endmodule

// File: rtl/fir_uart_rx.sv
// FIR upstream stage: UART bytes -> WIDTH-bit samples (low byte first),
// delivered to the FIR with a one-cycle valid pulse while fir_ready is high.
// Optional build macro: FIR_UART_RX_PARITY_EN (even parity per byte).
module fir_uart_rx
    import fir_uart_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             fir_ready,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int BYTES = WIDTH / BYTE_W;
    localparam int IW    = $clog2(BYTES) + 1;

    logic [BYTE_W-1:0] byte_data_s;
    logic              byte_done_s;
    logic              byte_err_s;

    logic [IW-1:0]    idx_q,     idx_d;
    logic [WIDTH-1:0] sreg_q,    sreg_d;
    logic [WIDTH-1:0] hold_q,    hold_d;
    logic [WIDTH-1:0] out_q,     out_d;
    logic             pending_q, pending_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             ovr_q,     ovr_d;
    logic [WIDTH-1:0] assembled_s;
    logic             last_s;
    logic             complete_s;
    logic             deliver_s;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rx_i        (rx),
        .byte_data_o (byte_data_s),
        .byte_done_o (byte_done_s),
        .byte_err_o  (byte_err_s)
    );

    // Shift register with the incoming byte dropped into its lane.
    always_comb begin
        assembled_s = sreg_q;
        for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IW'(k)) begin
                assembled_s[k*BYTE_W +: BYTE_W] = byte_data_s;
            end else begin
                assembled_s[k*BYTE_W +: BYTE_W] = sreg_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign last_s     = (idx_q == IW'(BYTES - 1));
    assign complete_s = byte_done_s && last_s;
    assign deliver_s  = pending_q && fir_ready;

    // Byte assembly, holding register, delivery and overrun decisions.
    always_comb begin
        idx_d     = idx_q;
        sreg_d    = sreg_q;
        hold_d    = hold_q;
        out_d     = out_q;
        pending_d = pending_q;
        valid_d   = deliver_s;
        ferr_d    = byte_err_s;
        ovr_d     = 1'b0;

        if (byte_done_s) begin
            sreg_d = assembled_s;
            if (last_s) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (byte_err_s) begin
            // A bad byte abandons the partially built sample.
            idx_d = {IW{1'b0}};
        end else begin
            idx_d = idx_q;
        end

        if (deliver_s) begin
            // Output register keeps the delivered value even if the holding
            // register is refilled on this same edge.
            out_d = hold_q;
            if (complete_s) begin
                hold_d    = assembled_s;
                pending_d = 1'b1;
            end else begin
                pending_d = 1'b0;
            end
        end else if (complete_s) begin
            if (pending_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_d    = assembled_s;
                pending_d = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end
    end

    // Assembly/delivery state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= {IW{1'b0}};
            sreg_q    <= {WIDTH{1'b0}};
            hold_q    <= {WIDTH{1'b0}};
            out_q     <= {WIDTH{1'b0}};
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            sreg_q    <= sreg_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_fir_uart_rx.sv
// Directed bench for fir_uart_rx with CLKS_PER_BIT = 8, WIDTH = 16.
// Parity cases are compiled in when FIR_UART_RX_PARITY_EN is defined.
module tb_fir_uart_rx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        fir_ready = 1'b1;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        frame_err;
    logic        overrun;

    int          n_vec = 0;
    int          n_miss = 0;
    int          v_cnt = 0;
    int          f_cnt = 0;
    int          o_cnt = 0;
    logic [15:0] last_smp = 16'h0000;
    int          v0, f0, o0;

    fir_uart_rx #(
        .WIDTH        (16),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .fir_ready    (fir_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters and captured sample, sampled away from the active edge.
    always @(negedge clk) begin
        if (sample_valid) begin
            v_cnt    <= v_cnt + 1;
            last_smp <= sample_out;
        end
        if (frame_err) f_cnt <= f_cnt + 1;
        if (overrun)   o_cnt <= o_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        idle(CPB);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef FIR_UART_RX_PARITY_EN
        bit_out(^d);
`endif
        bit_out(stop_b);
        rx = 1'b1;
        idle(CPB);
    endtask

`ifdef FIR_UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic p);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(p);
        bit_out(1'b1);
        rx = 1'b1;
        idle(CPB);
    endtask
`endif

    task automatic snap();
        v0 = v_cnt;
        f0 = f_cnt;
        o0 = o_cnt;
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        idle(4);

        // Basic sample 0x1234
        snap();
        send(8'h34, 1'b1);
        send(8'h12, 1'b1);
        chk("basic_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("basic_sample", 32'(last_smp), 32'h1234);
        chk("basic_frame_err", 32'(f_cnt - f0), 32'd0);
        chk("basic_overrun", 32'(o_cnt - o0), 32'd0);

        // Short low glitch is rejected silently
        snap();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * CPB);
        chk("glitch_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("glitch_frame_err", 32'(f_cnt - f0), 32'd0);

        // Bad stop bit drops the partial sample
        snap();
        send(8'h34, 1'b0);
        idle(2 * CPB);
        chk("ferr_pulse", 32'(f_cnt - f0), 32'd1);
        chk("ferr_no_valid", 32'(v_cnt - v0), 32'd0);
        send(8'h78, 1'b1);
        send(8'h56, 1'b1);
        chk("ferr_next_valid", 32'(v_cnt - v0), 32'd1);
        chk("ferr_next_sample", 32'(last_smp), 32'h5678);
        chk("ferr_once", 32'(f_cnt - f0), 32'd1);

        // Overrun while the FIR is busy
        snap();
        fir_ready = 1'b0;
        send(8'hEF, 1'b1);
        send(8'hBE, 1'b1);
        send(8'hFE, 1'b1);
        send(8'hCA, 1'b1);
        chk("ovr_pulse", 32'(o_cnt - o0), 32'd1);
        chk("ovr_no_valid", 32'(v_cnt - v0), 32'd0);
        chk("ovr_out_stable", 32'(sample_out), 32'h5678);
        fir_ready = 1'b1;
        idle(4);
        chk("ovr_deliver_cnt", 32'(v_cnt - v0), 32'd1);
        chk("ovr_deliver_sample", 32'(last_smp), 32'hBEEF);
        idle(2 * CPB);
        chk("ovr_single_pulse", 32'(v_cnt - v0), 32'd1);
        chk("ovr_no_more", 32'(o_cnt - o0), 32'd1);

        // Reset in the middle of the second byte's data bits
        send(8'h34, 1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        rst = 1'b0;
        rx = 1'b1;
        idle(1);
        chk("midrst_sample_out", 32'(sample_out), 32'h0);
        chk("midrst_valid", 32'(sample_valid), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);
        chk("midrst_overrun", 32'(overrun), 32'h0);
        idle(3);
        rst = 1'b1;
        idle(2 * CPB);
        snap();
        send(8'h01, 1'b1);
        send(8'h00, 1'b1);
        chk("midrst_next_valid", 32'(v_cnt - v0), 32'd1);
        chk("midrst_next_sample", 32'(last_smp), 32'h0001);
        chk("midrst_no_ferr", 32'(f_cnt - f0), 32'd0);

`ifdef FIR_UART_RX_PARITY_EN
        // Even parity: 0x03 needs parity bit 0
        snap();
        send_par(8'h03, 1'b1);
        idle(CPB);
        chk("par_bad_ferr", 32'(f_cnt - f0), 32'd1);
        send_par(8'h03, 1'b0);
        send(8'h00, 1'b1);
        chk("par_good_valid", 32'(v_cnt - v0), 32'd1);
        chk("par_good_sample", 32'(last_smp), 32'h0003);
        chk("par_ferr_once", 32'(f_cnt - f0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fir_uart_rx.md
Name: fir_uart_rx

Overview:
- Upstream stage of the FIR datapath.
- Receives 8N1 UART serial data, assembles consecutive bytes into WIDTH-bit samples (low byte first), and offers each sample to the FIR with a one-cycle valid pulse.
- Its valid pulse drives the FIR controller's valid_Input; the FIR's idle indication gates delivery.
- Reports framing errors and samples lost to overrun.

Parameters:
- WIDTH, 16: sample width; must be a multiple of 8; BYTES = WIDTH/8.
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200); must be >= 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rx  in  1  UART serial line, idle high, asynchronous to clk
- fir_ready  in  1  high while the FIR can accept a sample (FIR controller in Idle)
- sample_out  out  WIDTH  assembled sample; stable while pending
- sample_valid  out  1  one-cycle pulse; sample_out is valid in this cycle
- frame_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  one-cycle pulse when a completed sample is dropped

Behaviour:
- Reset (rst low, any time, including mid-frame):
  - FSM to IDLE; bit counter, clock counter, byte index, shift register and holding register cleared; pending cleared.
  - All outputs 0.
- Input synchroniser: rx passes through a 2-flop synchroniser, reset value 1. All sampling uses the synchronised value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised rx == 0; clock counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Sample 0 -> DATA. Sample 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register. After the 8th bit -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles, then always -> IDLE.
    - Sample 1: byte committed.
    - Sample 0: frame_err pulses one cycle, byte discarded, byte index reset to 0 (partial sample abandoned).
- Byte assembly:
  - Committed byte k (k = 0..BYTES-1) is written to bits [8k+7:8k] of the shift register.
  - When k == BYTES-1: shift register copied to the holding register, pending set, byte index wraps to 0.
- Delivery:
  - sample_valid = registered (pending && fir_ready). The pulse lasts exactly one cycle; pending clears on the same edge.
  - Latency: with fir_ready high, sample_valid is high in the 2nd cycle after the final stop-bit sample point.
  - fir_ready low: the sample waits indefinitely; sample_out holds the value.
- Overrun: a new sample completes while pending is still set -> new sample dropped, held sample kept, overrun pulses one cycle.
- Simultaneous events: if delivery and completion fall on the same edge, delivery wins, pending stays set with the new sample, and no overrun is raised.
- Widths: clock counter $clog2(CLKS_PER_BIT) bits; bit counter 3 bits; byte index $clog2(BYTES)+1 bits.

Optional Feature:
- Macro: FIR_UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that samples an even-parity bit. On mismatch, frame_err pulses at the stop-bit sample point and the byte is discarded exactly as for a bad stop bit.
- Undefined: pure 8N1, no PARITY state.

Decomposition:
- Package fir_uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, PARITY)
  - BYTE_W = 8
  - default CLKS_PER_BIT constant
- Sub-module uart_rx_byte: synchroniser plus bit FSM. Outputs byte_data[7:0], a byte_done pulse and a byte_err pulse.
- fir_uart_rx: byte assembly, holding register and delivery/overrun logic.

Test Plan (CLKS_PER_BIT = 8, WIDTH = 16):
- Send bytes 0x34 then 0x12, fir_ready = 1 -> single sample_valid pulse with sample_out = 0x1234; frame_err = overrun = 0.
- rx pulled low for 3 cycles then back high -> FSM returns to IDLE; no sample_valid and no frame_err.
- Send 0x34 with stop bit = 0, then 0x78, 0x56 -> frame_err pulses once; next sample_out = 0x5678 (partial byte discarded).
- fir_ready = 0; send 0xBEEF then 0xCAFE -> overrun pulses once. Then raise fir_ready -> sample_valid with sample_out = 0xBEEF, and exactly one pulse.
- rst driven low mid-DATA of the 2nd byte, then released; send 0x01, 0x00 -> sample_out = 0x0001; all outputs were 0 during reset.
- With FIR_UART_RX_PARITY_EN: byte 0x03 sent with parity bit 1 -> frame_err; sent with parity bit 0 -> byte accepted.
